cve2_xif_offload_ctrl: RTL



---
 rtl/cve2_xif_offload_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cve2_xif_offload_ctrl.sv
// Core-side CORE-V XIF offload sequencer: one offload at a time through issue, commit, register and result.
// Define CVE2_XIF_TIMEOUT_EN to add a result watchdog that raises an illegal-instruction exception.
module cve2_xif_offload_ctrl #(
  parameter int X_ID_WIDTH     = 4,
  parameter int X_NUM_RS       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_valid_i,
  input  logic [31:0]             instr_i,
  input  logic                    offload_req_i,
  input  logic                    kill_i,
  input  logic [31:0]             rs1_i,
  input  logic [31:0]             rs2_i,
  output logic                    stall_o,
  output logic                    offload_done_o,
  output logic                    offload_illegal_o,
  output logic                    exc_o,
  output logic [5:0]              exccode_o,
  output logic                    timeout_o,
  output logic                    rf_we_o,
  output logic [4:0]              rf_waddr_o,
  output logic [31:0]             rf_wdata_o,
  output logic                    x_issue_valid_o,
  input  logic                    x_issue_ready_i,
  output logic [31:0]             x_issue_instr_o,
  output logic [X_ID_WIDTH-1:0]   x_issue_id_o,
  input  logic                    x_issue_accept_i,
  input  logic                    x_issue_writeback_i,
  output logic                    x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0]   x_commit_id_o,
  output logic                    x_commit_kill_o,
  output logic                    x_register_valid_o,
  input  logic                    x_register_ready_i,
  output logic [X_ID_WIDTH-1:0]   x_register_id_o,
  output logic [32*X_NUM_RS-1:0]  x_register_rs_o,
  output logic [X_NUM_RS-1:0]     x_register_rs_valid_o,
  input  logic                    x_result_valid_i,
  output logic                    x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]   x_result_id_i,
  input  logic [31:0]             x_result_data_i,
  input  logic [4:0]              x_result_rd_i,
  input  logic                    x_result_we_i,
  input  logic                    x_result_exc_i,
  input  logic [5:0]              x_result_exccode_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, REGISTER, WAIT_RESULT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [X_ID_WIDTH-1:0] r_id;
  logic [X_ID_WIDTH-1:0] r_out_id;
  logic [31:0]           r_instr;
  logic                  r_kill_q;
  logic                  r_commit_valid;
  logic [X_ID_WIDTH-1:0] r_commit_id;
  logic                  r_commit_kill;
  logic                  r_done;
  logic                  r_illegal;
  logic                  r_exc;
  logic [5:0]            r_exccode;
  logic                  r_timeout;
  logic                  r_rf_we;
  logic [4:0]            r_rf_waddr;
  logic [31:0]           r_rf_wdata;

  logic w_start;
  logic w_issue_hs;
  logic w_reg_hs;
  logic w_result_match;
  logic w_timeout_hit;
  logic w_unused;

  assign w_start        = (r_state == IDLE) && instr_valid_i && offload_req_i && !kill_i;
  assign w_issue_hs     = (r_state == ISSUE) && x_issue_ready_i;
  assign w_reg_hs       = (r_state == REGISTER) && x_register_ready_i;
  assign w_result_match = (r_state == WAIT_RESULT) && x_result_valid_i && (x_result_id_i == r_out_id);
  assign w_unused       = x_issue_writeback_i ^ (TIMEOUT_CYCLES < 1);

`ifdef CVE2_XIF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_timer;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || r_state != WAIT_RESULT) r_timer <= '0;
    else                                   r_timer <= r_timer + 1'b1;
  end

  assign w_timeout_hit = (r_state == WAIT_RESULT) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next          = r_state;
    stall_o               = (r_state != IDLE) || w_start;
    x_issue_valid_o       = 1'b0;
    x_register_valid_o    = 1'b0;
    x_register_rs_o       = '0;
    x_register_rs_valid_o = '0;
    x_result_ready_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_next = ISSUE;
      end
      ISSUE: begin
        x_issue_valid_o = 1'b1;
        if (w_issue_hs) w_state_next = x_issue_accept_i ? REGISTER : IDLE;
      end
      REGISTER: begin
        x_register_valid_o    = 1'b1;
        x_register_rs_o       = {rs2_i, rs1_i};
        x_register_rs_valid_o = '1;
        if (w_reg_hs) w_state_next = r_kill_q ? IDLE : WAIT_RESULT;
      end
      WAIT_RESULT: begin
        x_result_ready_o = 1'b1;
        if (w_result_match || w_timeout_hit) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pulses default low every cycle; a kill sampled on the handshake cycle still reaches the commit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_id           <= '0;
      r_out_id       <= '0;
      r_instr        <= '0;
      r_kill_q       <= 1'b0;
      r_commit_valid <= 1'b0;
      r_commit_id    <= '0;
      r_commit_kill  <= 1'b0;
      r_done         <= 1'b0;
      r_illegal      <= 1'b0;
      r_exc          <= 1'b0;
      r_exccode      <= '0;
      r_timeout      <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
    end else begin
      r_commit_valid <= 1'b0;
      r_done         <= 1'b0;
      r_illegal      <= 1'b0;
      r_exc          <= 1'b0;
      r_exccode      <= '0;
      r_timeout      <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      if (w_start) begin
        r_instr  <= instr_i;
        r_kill_q <= 1'b0;
      end
      if (r_state == ISSUE && kill_i) r_kill_q <= 1'b1;
      if (w_issue_hs) begin
        r_id           <= r_id + 1'b1;
        r_out_id       <= r_id;
        r_commit_valid <= 1'b1;
        r_commit_id    <= r_id;
        r_commit_kill  <= r_kill_q || kill_i || !x_issue_accept_i;
        r_illegal      <= !x_issue_accept_i;
      end
      if (w_reg_hs && r_kill_q) r_done <= 1'b1;
      if (w_result_match) begin
        r_done <= 1'b1;
        r_exc  <= x_result_exc_i;
        if (x_result_exc_i) r_exccode <= x_result_exccode_i;
        if (x_result_we_i && !x_result_exc_i) begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= x_result_rd_i;
          r_rf_wdata <= x_result_data_i;
        end
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
        r_exc     <= 1'b1;
        r_exccode <= 6'd2;
      end
    end
  end

  assign offload_done_o    = r_done;
  assign offload_illegal_o = r_illegal;
  assign exc_o             = r_exc;
  assign exccode_o         = r_exccode;
  assign timeout_o         = r_timeout;
  assign rf_we_o           = r_rf_we;
  assign rf_waddr_o        = r_rf_waddr;
  assign rf_wdata_o        = r_rf_wdata;
  assign x_issue_instr_o   = r_instr;
  assign x_issue_id_o      = r_id;
  assign x_commit_valid_o  = r_commit_valid;
  assign x_commit_id_o     = r_commit_id;
  assign x_commit_kill_o   = r_commit_kill;
  assign x_register_id_o   = r_out_id;

endmodule
